// File: rtl/lc4_iq_pkg.sv
// Shared types and constants for the LC4 issue-queue scheduler.
package lc4_iq_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int PRD_W    = 4;
  localparam int INSN_W   = 16;

  typedef enum logic [1:0] {CHK1, CHK2, ISSUE} state_t;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [PRD_W-1:0]  prd;
    logic [PRD_W-1:0]  ps1;
    logic [PRD_W-1:0]  ps2;
    logic              ps1_v;
    logic              ps2_v;
  } entry_t;

endpackage

// File: rtl/lc4_iq_retire.sv
// In-order retire: owns the head pointer, emits a registered one-cycle retire pulse
// and tells the queue when an entry is freed (count decrement).
module lc4_iq_retire
  import lc4_iq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [IQ_DEPTH-1:0]     valid,
  input  logic [IQ_DEPTH-1:0]     commit,
  input  logic [IQ_DEPTH*PRD_W-1:0] prd_flat,
  output logic [1:0]              head,
  output logic                    fire,
  output logic                    retire_valid,
  output logic [1:0]              retire_idx,
  output logic [PRD_W-1:0]        retire_prd
);

  assign fire = valid[head] & commit[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      retire_valid <= 1'b0;
      retire_idx   <= '0;
      retire_prd   <= '0;
    end else if (flush) begin
      head         <= '0;
      retire_valid <= 1'b0;
    end else begin
      retire_valid <= fire;
      if (fire) begin
        retire_idx <= head;
        retire_prd <= prd_flat[{head, 2'b00} +: PRD_W];
        head       <= head + 2'd1;
      end
    end
  end

endmodule

// File: rtl/lc4_iq_scheduler.sv
// 4-entry LC4 issue queue: allocation, oldest-first operand scan, issue handshake, completion.
// Optional performance counters are built when LC4_IQ_PERF_EN is defined.
module lc4_iq_scheduler #(
  parameter int DEPTH  = 4,
  parameter int PRD_W  = 4,
  parameter int INSN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [INSN_W-1:0]   alloc_insn,
  input  logic [PRD_W-1:0]    alloc_prd,
  input  logic [PRD_W-1:0]    alloc_ps1,
  input  logic [PRD_W-1:0]    alloc_ps2,
  input  logic                alloc_ps1_v,
  input  logic                alloc_ps2_v,
  output logic [4*INSN_W-1:0] iq_insn_flat,
  output logic [4*PRD_W-1:0]  iq_prd_flat,
  output logic [3:0]          iq_valid,
  output logic [3:0]          iq_issue,
  output logic [3:0]          iq_commit,
  output logic [1:0]          sb_iqx,
  output logic [PRD_W-1:0]    sb_pri,
  input  logic                sb_raw,
  input  logic                sb_ready,
  input  logic [INSN_W-1:0]   sb_bypass,
  output logic                issue_valid,
  input  logic                issue_ack,
  output logic [1:0]          issue_idx,
  output logic [INSN_W-1:0]   issue_insn,
  output logic [PRD_W-1:0]    issue_prd,
  output logic                issue_op1_byp,
  output logic                issue_op2_byp,
  output logic [INSN_W-1:0]   issue_op1_data,
  output logic [INSN_W-1:0]   issue_op2_data,
  input  logic                done_valid,
  input  logic [1:0]          done_idx,
  output logic                retire_valid,
  output logic [1:0]          retire_idx,
  output logic [PRD_W-1:0]    retire_prd,
  output logic [15:0]         perf_issued,
  output logic [15:0]         perf_stalls
);
  import lc4_iq_pkg::*;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  entry_t      ent [IQ_DEPTH];
  logic [3:0]  valid, issue, commit;
  logic [1:0]  tail, scan, head;
  logic [2:0]  count;
  state_t      state;
  logic        op1_byp, op2_byp;
  logic [INSN_W-1:0] op1_data, op2_data;

  entry_t      cur;
  logic        cand, chk_v, avail, byp, alloc_fire, ack_fire, retire_fire;
  logic [1:0]  scan_next;

  assign cur         = ent[scan];
  assign cand        = valid[scan] & ~issue[scan];
  assign chk_v       = (state == CHK2) ? cur.ps2_v : cur.ps1_v;
  assign avail       = ~chk_v | sb_ready | ~sb_raw;
  assign byp         = ~sb_ready & ~sb_raw;
  // Wrap to the oldest entry once the youngest has been examined.
  assign scan_next   = ((count == 3'd0) || (scan == tail - 2'd1)) ? head : scan + 2'd1;
  assign alloc_ready = (count < DEPTH_C);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign ack_fire    = (state == ISSUE) & issue_ack;

  assign sb_iqx         = scan;
  assign sb_pri         = (state == CHK2) ? cur.ps2 : cur.ps1;
  assign issue_valid    = (state == ISSUE);
  assign issue_idx      = scan;
  assign issue_insn     = cur.insn;
  assign issue_prd      = cur.prd;
  assign issue_op1_byp  = op1_byp;
  assign issue_op2_byp  = op2_byp;
  assign issue_op1_data = op1_data;
  assign issue_op2_data = op2_data;
  assign iq_valid       = valid;
  assign iq_issue       = issue;
  assign iq_commit      = commit;

  always_comb begin
    iq_insn_flat = '0;
    iq_prd_flat  = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      iq_insn_flat[INSN_W*i +: INSN_W] = ent[i].insn;
      iq_prd_flat[PRD_W*i +: PRD_W]    = ent[i].prd;
    end
  end

  lc4_iq_retire u_retire (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .valid        (valid),
    .commit       (commit),
    .prd_flat     (iq_prd_flat),
    .head         (head),
    .fire         (retire_fire),
    .retire_valid (retire_valid),
    .retire_idx   (retire_idx),
    .retire_prd   (retire_prd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent[i] <= '0;
      valid <= '0; issue <= '0; commit <= '0;
      tail <= '0; count <= '0; scan <= '0; state <= CHK1;
      op1_byp <= 1'b0; op2_byp <= 1'b0; op1_data <= '0; op2_data <= '0;
    end else if (flush) begin
      for (int i = 0; i < IQ_DEPTH; i++) ent[i] <= '0;
      valid <= '0; issue <= '0; commit <= '0;
      tail <= '0; count <= '0; scan <= '0; state <= CHK1;
      op1_byp <= 1'b0; op2_byp <= 1'b0; op1_data <= '0; op2_data <= '0;
    end else begin
      count <= count + {2'b00, alloc_fire} - {2'b00, retire_fire};
      if (alloc_fire) begin
        ent[tail] <= '{insn: alloc_insn, prd: alloc_prd, ps1: alloc_ps1, ps2: alloc_ps2,
                       ps1_v: alloc_ps1_v, ps2_v: alloc_ps2_v};
        valid[tail]  <= 1'b1;
        issue[tail]  <= 1'b0;
        commit[tail] <= 1'b0;
        tail         <= tail + 2'd1;
      end
      // An entry acked this cycle is not yet issued, so a same-cycle done is dropped.
      if (done_valid && valid[done_idx] && issue[done_idx]) commit[done_idx] <= 1'b1;
      if (ack_fire) issue[scan] <= 1'b1;
      if (retire_fire) begin
        ent[head]    <= '0;
        valid[head]  <= 1'b0;
        issue[head]  <= 1'b0;
        commit[head] <= 1'b0;
      end
      case (state)
        CHK1: begin
          if (!cand) begin
            scan <= scan_next;
          end else begin
            op1_byp  <= byp;
            op1_data <= byp ? sb_bypass : '0;
            if (avail) state <= CHK2;
            else       scan  <= scan_next;
          end
        end
        CHK2: begin
          op2_byp  <= byp;
          op2_data <= byp ? sb_bypass : '0;
          if (avail) begin
            state <= ISSUE;
          end else begin
            scan  <= scan_next;
            state <= CHK1;
          end
        end
        ISSUE: begin
          if (issue_ack) begin
            scan  <= head;
            state <= CHK1;
          end
        end
        default: state <= CHK1;
      endcase
    end
  end

`ifdef LC4_IQ_PERF_EN
  logic        stall;
  logic [15:0] issued_q, stalls_q;

  assign stall = ((state == CHK1) & cand & ~avail) | ((state == CHK2) & ~avail);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stalls_q <= '0;
    end else begin
      if (ack_fire && !flush && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (stall && stalls_q != 16'hFFFF) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign perf_issued = issued_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_issued = 16'd0;
  assign perf_stalls = 16'd0;
`endif

endmodule

// File: tb/tb_lc4_iq_scheduler.sv
// Bench for lc4_iq_scheduler: table-driven issue order, hand-written corner sequences,
// and a random phase checked against a transaction-level queue model.
module tb_lc4_iq_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [15:0] alloc_insn = '0;
  logic [3:0]  alloc_prd = '0, alloc_ps1 = '0, alloc_ps2 = '0;
  logic        alloc_ps1_v = 1'b0, alloc_ps2_v = 1'b0;
  logic [63:0] iq_insn_flat;
  logic [15:0] iq_prd_flat;
  logic [3:0]  iq_valid, iq_issue, iq_commit;
  logic [1:0]  sb_iqx;
  logic [3:0]  sb_pri;
  logic        sb_raw, sb_ready;
  logic [15:0] sb_bypass;
  logic        issue_valid;
  logic        issue_ack = 1'b0;
  logic [1:0]  issue_idx;
  logic [15:0] issue_insn;
  logic [3:0]  issue_prd;
  logic        issue_op1_byp, issue_op2_byp;
  logic [15:0] issue_op1_data, issue_op2_data;
  logic        done_valid = 1'b0;
  logic [1:0]  done_idx = '0;
  logic        retire_valid;
  logic [1:0]  retire_idx;
  logic [3:0]  retire_prd;
  logic [15:0] perf_issued, perf_stalls;

  lc4_iq_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_insn(alloc_insn),
    .alloc_prd(alloc_prd), .alloc_ps1(alloc_ps1), .alloc_ps2(alloc_ps2),
    .alloc_ps1_v(alloc_ps1_v), .alloc_ps2_v(alloc_ps2_v),
    .iq_insn_flat(iq_insn_flat), .iq_prd_flat(iq_prd_flat),
    .iq_valid(iq_valid), .iq_issue(iq_issue), .iq_commit(iq_commit),
    .sb_iqx(sb_iqx), .sb_pri(sb_pri), .sb_raw(sb_raw), .sb_ready(sb_ready), .sb_bypass(sb_bypass),
    .issue_valid(issue_valid), .issue_ack(issue_ack), .issue_idx(issue_idx),
    .issue_insn(issue_insn), .issue_prd(issue_prd),
    .issue_op1_byp(issue_op1_byp), .issue_op2_byp(issue_op2_byp),
    .issue_op1_data(issue_op1_data), .issue_op2_data(issue_op2_data),
    .done_valid(done_valid), .done_idx(done_idx),
    .retire_valid(retire_valid), .retire_idx(retire_idx), .retire_prd(retire_prd),
    .perf_issued(perf_issued), .perf_stalls(perf_stalls)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Scoreboard stand-in: busy tags report RAW, byp tags report the bypass path.
  logic [15:0] busy = '0;
  logic [15:0] bypr = '0;
  assign sb_raw    = busy[sb_pri];
  assign sb_ready  = ~busy[sb_pri] & ~bypr[sb_pri];
  assign sb_bypass = {12'h123, sb_pri};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct {
    logic [1:0]  idx;
    logic [15:0] insn;
    logic [3:0]  prd, ps1, ps2;
    logic        ps1_v, ps2_v;
    bit          issued, committed;
  } mentry_t;

  mentry_t     mq[$];
  logic [3:0]  exp_q[$];
  logic [1:0]  m_tail;
  logic        exp_ret_v;
  logic [1:0]  exp_ret_idx;
  int          n_acks;
  bit          draining;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alloc_valid = 1'b0; issue_ack = 1'b0; done_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mq.delete(); exp_q.delete();
    m_tail = '0; exp_ret_v = 1'b0; n_acks = 0;
  endtask

  task automatic alloc1(input logic [15:0] insn, input logic [3:0] prd,
                        input logic p1v, input logic [3:0] p1, input logic p2v, input logic [3:0] p2);
    alloc_valid = 1'b1; alloc_insn = insn; alloc_prd = prd;
    alloc_ps1_v = p1v; alloc_ps1 = p1; alloc_ps2_v = p2v; alloc_ps2 = p2;
    chk("alloc_ready_before_alloc", alloc_ready, 1);
    @(negedge clk);
    alloc_valid = 1'b0;
  endtask

  task automatic wait_issue();
    for (int i = 0; i < 60 && !issue_valid; i++) @(negedge clk);
    chk("issue_timeout", issue_valid, 1);
  endtask

  task automatic take_issue(input logic [1:0] idx, input logic [15:0] insn, input logic [3:0] prd);
    wait_issue();
    chk("issue_idx", issue_idx, idx);
    chk("issue_insn", issue_insn, insn);
    chk("issue_prd", issue_prd, prd);
    issue_ack = 1'b1;
    @(negedge clk);
    issue_ack = 1'b0;
    chk("issue_drop_after_ack", issue_valid, 0);
  endtask

  // One random cycle: check outputs against the model, drive, then advance the model.
  task automatic rnd_cycle();
    int k;
    int cands[$];
    logic ok_src, alloc_ok;
    @(negedge clk);
    chk("rnd_alloc_ready", alloc_ready, (mq.size() < 4));
    chk("rnd_retire_valid", retire_valid, exp_ret_v);
    if (exp_ret_v) begin
      chk("rnd_retire_idx", retire_idx, exp_ret_idx);
      chk("rnd_retire_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rnd_retire_prd", retire_prd, exp_q.pop_front());
    end
    if (issue_valid) begin
      k = -1;
      for (int j = 0; j < mq.size(); j++) if (mq[j].idx == issue_idx) k = j;
      chk("rnd_issue_is_live", k >= 0, 1);
      if (k >= 0) begin
        ok_src = (!mq[k].ps1_v || !busy[mq[k].ps1]) && (!mq[k].ps2_v || !busy[mq[k].ps2]);
        chk("rnd_issue_insn", issue_insn, mq[k].insn);
        chk("rnd_issue_prd", issue_prd, mq[k].prd);
        chk("rnd_issue_not_reissued", mq[k].issued, 0);
        chk("rnd_issue_sources_ready", ok_src, 1);
      end
    end

    // drive
    alloc_valid = !draining && ($urandom_range(0, 99) < 50);
    alloc_insn  = 16'($urandom());
    alloc_prd   = 4'($urandom_range(0, 15));
    alloc_ps1   = 4'($urandom_range(0, 15));
    alloc_ps2   = 4'($urandom_range(0, 15));
    alloc_ps1_v = 1'($urandom_range(0, 1));
    alloc_ps2_v = 1'($urandom_range(0, 1));
    issue_ack   = issue_valid && ($urandom_range(0, 99) < 60);
    for (int j = 0; j < mq.size(); j++) if (mq[j].issued && !mq[j].committed) cands.push_back(j);
    done_valid = 1'b0;
    if (cands.size() > 0 && $urandom_range(0, 99) < 40) begin
      done_valid = 1'b1;
      done_idx   = mq[cands[$urandom_range(0, cands.size() - 1)]].idx;
    end else if ($urandom_range(0, 99) < 5) begin
      done_valid = 1'b1;
      done_idx   = 2'($urandom_range(0, 3));
    end
    if ($urandom_range(0, 99) < 10) busy[$urandom_range(0, 15)] = 1'b0;
    if (!draining && mq.size() == 0 && $urandom_range(0, 99) < 5) busy = 16'($urandom());

    // model: retire decided on pre-edge state, then done, ack, alloc
    alloc_ok  = alloc_valid && (mq.size() < 4);
    exp_ret_v = (mq.size() > 0) && mq[0].committed;
    if (exp_ret_v) begin
      exp_ret_idx = mq[0].idx;
      void'(mq.pop_front());
    end
    if (done_valid)
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].idx == done_idx && mq[j].issued) mq[j].committed = 1'b1;
    if (issue_valid && issue_ack) begin
      n_acks++;
      for (int j = 0; j < mq.size(); j++) if (mq[j].idx == issue_idx) mq[j].issued = 1'b1;
    end
    if (alloc_ok) begin
      mq.push_back('{idx: m_tail, insn: alloc_insn, prd: alloc_prd, ps1: alloc_ps1, ps2: alloc_ps2,
                     ps1_v: alloc_ps1_v, ps2_v: alloc_ps2_v, issued: 1'b0, committed: 1'b0});
      exp_q.push_back(alloc_prd);
      m_tail = m_tail + 2'd1;
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [15:0] insn;
    logic [3:0]  prd;
    logic [1:0]  exp_idx;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{insn: 16'h1241, prd: 4'd8,  exp_idx: 2'd0};
    vecs[1] = '{insn: 16'h1282, prd: 4'd9,  exp_idx: 2'd1};
    vecs[2] = '{insn: 16'h12C3, prd: 4'd10, exp_idx: 2'd2};
    vecs[3] = '{insn: 16'h1304, prd: 4'd11, exp_idx: 2'd3};
    draining = 1'b0;
    m_tail = '0; exp_ret_v = 1'b0; n_acks = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_iq_valid", iq_valid, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_insn_flat", iq_insn_flat, 0);
    chk("rst_sb_iqx", sb_iqx, 0);
    rst = 1'b0;
    @(negedge clk);

    // alloc into empty queue: issue_valid on the 3rd cycle after the allocating edge
    alloc1(16'h1111, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("lat_cycle1", issue_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", issue_valid, 0);
    @(negedge clk);
    chk("lat_cycle3", issue_valid, 1);
    chk("lat_idx", issue_idx, 0);

    // async reset mid-ISSUE
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_issue_valid", issue_valid, 0);
    chk("rst_mid_alloc_ready", alloc_ready, 1);
    chk("rst_mid_iq_valid", iq_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // four independent allocs issue in order
    for (int i = 0; i < 4; i++)
      alloc1(vecs[i].insn, vecs[i].prd, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("full_alloc_ready", alloc_ready, 0);
    for (int i = 0; i < 4; i++) take_issue(vecs[i].exp_idx, vecs[i].insn, vecs[i].prd);
    do_reset();

    // blocked older entry lets a younger one issue first
    busy[5] = 1'b1;
    alloc1(16'h2000, 4'd6, 1'b1, 4'd5, 1'b0, 4'd0);
    alloc1(16'h2001, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    take_issue(2'd1, 16'h2001, 4'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dep_hold", issue_valid, 0);
    end
    busy[5] = 1'b0;
    take_issue(2'd0, 16'h2000, 4'd6);

    // out-of-order completion, in-order retire
    done_valid = 1'b1; done_idx = 2'd1;
    @(negedge clk);
    done_valid = 1'b0;
    chk("ret_wait_a", retire_valid, 0);
    @(negedge clk);
    chk("ret_wait_b", retire_valid, 0);
    done_valid = 1'b1; done_idx = 2'd0;
    @(negedge clk);
    done_valid = 1'b0;
    chk("ret_wait_c", retire_valid, 0);
    @(negedge clk);
    chk("ret0_valid", retire_valid, 1);
    chk("ret0_idx", retire_idx, 0);
    chk("ret0_prd", retire_prd, 6);
    @(negedge clk);
    chk("ret1_valid", retire_valid, 1);
    chk("ret1_idx", retire_idx, 1);
    chk("ret1_prd", retire_prd, 7);
    chk("ret_iq_valid", iq_valid, 0);
    @(negedge clk);
    chk("ret_pulse_end", retire_valid, 0);
    do_reset();

    // bypass capture on op1
    bypr[4] = 1'b1;
    alloc1(16'h3000, 4'd9, 1'b1, 4'd4, 1'b0, 4'd0);
    wait_issue();
    chk("byp_idx", issue_idx, 0);
    chk("byp_op1", issue_op1_byp, 1);
    chk("byp_op1_data", issue_op1_data, 16'h1234);
    chk("byp_op2", issue_op2_byp, 0);
    bypr[4] = 1'b0;

    // flush while offered, with a coincident ack that must be ignored
    flush = 1'b1; issue_ack = 1'b1;
    @(negedge clk);
    flush = 1'b0; issue_ack = 1'b0;
    chk("flush_issue_valid", issue_valid, 0);
    chk("flush_iq_valid", iq_valid, 0);
    chk("flush_alloc_ready", alloc_ready, 1);
    alloc1(16'h4000, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("flush_realloc_slot", iq_valid, 4'b0001);
    take_issue(2'd0, 16'h4000, 4'd2);
    do_reset();

    // random phase against the queue model, then drain
    busy = 16'($urandom());
    for (int c = 0; c < 1500; c++) rnd_cycle();
    draining = 1'b1;
    busy = '0;
    for (int c = 0; c < 600 && (mq.size() > 0 || exp_ret_v); c++) rnd_cycle();
    chk("rnd_drain_model_empty", mq.size(), 0);
    @(negedge clk);
    chk("rnd_drain_exp_q_empty", exp_q.size(), 0);
    chk("rnd_drain_iq_valid", iq_valid, 0);
`ifdef LC4_IQ_PERF_EN
    chk("perf_issued", perf_issued, (n_acks > 65535) ? 16'hFFFF : 16'(n_acks));
`else
    chk("perf_issued_tied", perf_issued, 0);
    chk("perf_stalls_tied", perf_stalls, 0);
`endif

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc4_iq_scheduler.md
Name: lc4_iq_scheduler

Overview:
- Controller for the 4-entry issue queue of the LC4 out-of-order core.
- Owns the entries and their per-entry valid/issue/commit state, and accepts allocations from rename.
- Walks the entries oldest-first, asking the scoreboard about each source physical register through its iqx/iqx_pri query port.
- Issues one ready instruction at a time with a valid/ack handshake, and retires completed entries in order.

Parameters:
- DEPTH, 4: number of queue entries. Only 4 is supported, fixed by the scoreboard's 2-bit iqx.
- PRD_W, 4: width of a physical register tag.
- INSN_W, 16: LC4 instruction width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash all entries
- alloc_valid  in  1  rename presents an instruction
- alloc_ready  out  1  queue has a free entry
- alloc_insn  in  16  instruction
- alloc_prd  in  4  destination physical tag
- alloc_ps1, alloc_ps2  in  4 each  source physical tags
- alloc_ps1_v, alloc_ps2_v  in  1 each  source is used
- iq_insn_flat  out  64  entry i occupies bits [16i+15:16i]; feeds scoreboard iqN_insn
- iq_prd_flat  out  16  entry i occupies bits [4i+3:4i]; feeds scoreboard iqN_prd
- iq_valid, iq_issue, iq_commit  out  4 each  per-entry state bits
- sb_iqx  out  2  entry being checked
- sb_pri  out  4  source tag being checked
- sb_raw, sb_ready  in  1 each  scoreboard response
- sb_bypass  in  16  scoreboard bypass data
- issue_valid  out  1  an instruction is offered for issue
- issue_ack  in  1  execute accepts the offered instruction
- issue_idx  out  2  entry index of the offered instruction
- issue_insn  out  16  offered instruction
- issue_prd  out  4  offered destination tag
- issue_op1_byp, issue_op2_byp  out  1 each  operand comes from the captured bypass value
- issue_op1_data, issue_op2_data  out  16 each  captured bypass values
- done_valid  in  1  an issued instruction has completed
- done_idx  in  2  entry index of the completed instruction
- retire_valid  out  1  one-cycle retire pulse
- retire_idx  out  2  entry index being retired
- retire_prd  out  4  destination tag being retired
- perf_issued, perf_stalls  out  16 each  performance counters

Behaviour:
- Reset (async, `rst`=1):
  - all entry bits cleared; head=tail=0; count=0; scan=0; state=CHK1.
  - All outputs 0 except alloc_ready=1.
  - Reset asserted mid-handshake drops issue_valid immediately.
- Allocation:
  - alloc_ready = (count<4).
  - On alloc_valid&alloc_ready: write entry[tail]; set valid; clear issue and commit; tail+=1 (mod 4).
  - A retire in the same cycle does not raise alloc_ready; the freed slot is usable the next cycle.
- Scan FSM:
  - CHK1: sb_iqx=scan, sb_pri=ps1 of the entry.
    - A candidate is an entry with valid&~issue.
    - Non-candidate: scan+=1, stay in CHK1.
    - Candidate: the operand is available if ~ps1_v | sb_ready | ~sb_raw. When ~sb_ready&~sb_raw, latch op1_byp=1 and op1_data=sb_bypass; otherwise op1_byp=0.
    - Operand available: go to CHK2. Otherwise scan+=1, stay in CHK1.
  - CHK2: same check for ps2. Available: go to ISSUE. Otherwise scan+=1, go to CHK1.
  - Scan wrap:
    - One operand check per cycle, including unused operands.
    - After checking the entry at tail-1, or when count==0, scan=head.
  - ISSUE: issue_valid=1, with issue_* driven from entry[scan] and the latched operands. On issue_ack: set issue[scan]; scan=head; go to CHK1.
  - Latency: an alloc into an empty queue with scan==head gives issue_valid on the 3rd cycle after the allocating edge.
- Completion:
  - done_valid sets commit[done_idx] only if valid&issue.
  - Otherwise it is ignored.
- Retire:
  - When valid[head]&commit[head]: retire_valid=1 (registered, one cycle) with retire_idx/retire_prd.
  - Clear all bits of the entry; head+=1; count-=1.
  - At most one retire per cycle.
- Simultaneous events:
  - Alloc and retire in the same cycle: count is unchanged.
  - done_valid for the entry being acked in the same cycle is ignored.
- Flush (synchronous, highest priority):
  - Clears all entry bits, head, tail, count and scan; state=CHK1.
  - issue_valid is 0 from the next cycle.
  - The current issue_ack is ignored.

Optional Feature:
- LC4_IQ_PERF_EN defined:
  - perf_issued increments on each issue_valid&issue_ack.
  - perf_stalls increments on each CHK1/CHK2 cycle whose operand is unavailable.
  - Both counters saturate at 16'hFFFF; they are cleared by rst, not by flush.
- Not defined: both counters tied to 16'd0, with no counter flops.

Decomposition:
- Package lc4_iq_pkg holds:
  - IQ_DEPTH=4 and the PRD_W and INSN_W constants.
  - State enum {CHK1, CHK2, ISSUE}.
  - Entry struct {insn, prd, ps1, ps2, ps1_v, ps2_v}.
- One sub-module, lc4_iq_retire: head pointer, in-order retire pulse and count-decrement logic.

Test Plan:
- Reset mid-ISSUE with issue_valid=1 -> issue_valid=0 while rst is high, alloc_ready=1, iq_valid=4'b0000.
- Alloc 4 independent ADDs (ps*_v=0), ack on every issue_valid -> issues in order idx 0,1,2,3; alloc_ready=0 after the 4th alloc.
- Entry0 ps1=4'd5 with sb_raw=1 whenever sb_pri==5, entry1 independent -> entry1 issues first; entry0 issues after sb_raw drops.
- Entry0 ps1 check sees sb_ready=0, sb_raw=0, sb_bypass=16'h1234 -> issue_op1_byp=1, issue_op1_data=16'h1234.
- done idx1, then done idx0 two cycles later -> no retire until idx0 is done; then retire idx0 and idx1 on consecutive cycles, iq_valid=4'b0000.
- Flush while issue_valid=1 and issue_ack=0 -> next cycle issue_valid=0 and iq_valid=0; a fresh alloc lands in idx0.
